mfb_frame_gen: RTL and testbench

Single-region MFB frame transmitter. It accepts frame requests (length in items plus metadata) on a valid/ready interface and emits each frame on an MFB TX port with correct SOF/EOF/SOF_POS/EOF_POS and a deterministic data pattern. It is the source end of the MFB protocol, used to drive the RX side of MFB blocks under test (for example MFB_RECONFIGURATOR) and as an on-chip traffic generator.

---
 rtl/mfb_frame_gen.sv | 182 ++++++++++++++++++
 tb/tb_mfb_frame_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfb_frame_gen.sv
// Single-region MFB frame source: turns (length, metadata) requests into MFB words
// carrying an incrementing item pattern with SOF/EOF framing and a completed-frame counter.
module mfb_frame_gen #(
  parameter int REGION_SIZE = 8,
  parameter int BLOCK_SIZE  = 8,
  parameter int ITEM_WIDTH  = 8,
  parameter int META_WIDTH  = 16,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [LEN_WIDTH-1:0]                       req_len_i,
  input  logic [META_WIDTH-1:0]                      req_meta_i,
  input  logic                                       req_vld_i,
  output logic                                       req_rdy_o,
  output logic [REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] tx_data_o,
  output logic [META_WIDTH-1:0]                      tx_meta_o,
  output logic                                       tx_sof_o,
  output logic                                       tx_eof_o,
  output logic [$clog2(REGION_SIZE)-1:0]             tx_sof_pos_o,
  output logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]  tx_eof_pos_o,
  output logic                                       tx_src_rdy_o,
  input  logic                                       tx_dst_rdy_i,
  output logic [31:0]                                frames_sent_o
);
  localparam int WORD_ITEMS = REGION_SIZE * BLOCK_SIZE;
  localparam int DATA_W     = WORD_ITEMS * ITEM_WIDTH;
  localparam int LOG_WI     = $clog2(WORD_ITEMS);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    last_q, last_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [META_WIDTH-1:0]   meta_q, meta_d;
  logic                    sof_q, sof_d;
  logic                    eof_q, eof_d;
  logic [LOG_WI-1:0]       eof_pos_q, eof_pos_d;
  logic                    src_rdy_q, src_rdy_d;
  logic [31:0]             frames_q, frames_d;
  logic                    up_q;

  logic                    is_last_s;
  logic                    req_rdy_s;
  logic                    new_frame_s;
  logic [LEN_WIDTH-1:0]    req_last_s;
  logic [LEN_WIDTH-1:0]    cnt_inc_s;

  // Word widx of a len-item frame: item i = frame index mod 2^ITEM_WIDTH, zero past the end.
  function automatic logic [DATA_W-1:0] build_word(input logic [LEN_WIDTH-1:0] len,
                                                   input logic [LEN_WIDTH-1:0] widx);
    logic [LEN_WIDTH-1:0] base;
    logic [LEN_WIDTH-1:0] rem;
    logic [DATA_W-1:0]    word;
    base = widx << LOG_WI;
    rem  = len - base;
    word = '0;
    for (int i = 0; i < WORD_ITEMS; i++) begin
      if (LEN_WIDTH'(i) < rem) begin
        word[i*ITEM_WIDTH +: ITEM_WIDTH] = ITEM_WIDTH'(base + LEN_WIDTH'(i));
      end else begin
        word[i*ITEM_WIDTH +: ITEM_WIDTH] = '0;
      end
    end
    return word;
  endfunction

  assign is_last_s   = (state_q == SEND) && (cnt_q == last_q);
  assign req_rdy_s   = up_q && ((state_q == IDLE) || (is_last_s && tx_dst_rdy_i));
  assign new_frame_s = req_vld_i && req_rdy_s && (req_len_i != '0);
  assign req_last_s  = (req_len_i - LEN_WIDTH'(1)) >> LOG_WI;
  assign cnt_inc_s   = cnt_q + LEN_WIDTH'(1);

  // Next-state and output-register load logic.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    meta_d    = meta_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
    eof_pos_d = eof_pos_q;
    src_rdy_d = src_rdy_q;
    frames_d  = frames_q;

    case (state_q)
      IDLE: begin
        if (new_frame_s) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (tx_dst_rdy_i && is_last_s && !new_frame_s) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase

    if (is_last_s && tx_dst_rdy_i) begin
      frames_d = frames_q + 32'd1;
    end else begin
      frames_d = frames_q;
    end

    // A new frame always starts in word 0; otherwise a transfer advances or closes the frame.
    if (new_frame_s) begin
      len_d     = req_len_i;
      last_d    = req_last_s;
      cnt_d     = '0;
      data_d    = build_word(req_len_i, '0);
      meta_d    = req_meta_i;
      sof_d     = 1'b1;
      eof_d     = (req_last_s == '0);
      eof_pos_d = LOG_WI'(req_len_i - LEN_WIDTH'(1));
      src_rdy_d = 1'b1;
    end else if ((state_q == SEND) && tx_dst_rdy_i) begin
      if (is_last_s) begin
        src_rdy_d = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
      end else begin
        cnt_d  = cnt_inc_s;
        data_d = build_word(len_q, cnt_inc_s);
        sof_d  = 1'b0;
        eof_d  = (cnt_inc_s == last_q);
      end
    end else begin
      src_rdy_d = src_rdy_q;
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      meta_q    <= '0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      eof_pos_q <= '0;
      src_rdy_q <= 1'b0;
      frames_q  <= 32'd0;
      up_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      meta_q    <= meta_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      eof_pos_q <= eof_pos_d;
      src_rdy_q <= src_rdy_d;
      frames_q  <= frames_d;
      up_q      <= 1'b1;
    end
  end

  assign req_rdy_o     = req_rdy_s;
  assign tx_data_o     = data_q;
  assign tx_meta_o     = meta_q;
  assign tx_sof_o      = sof_q;
  assign tx_eof_o      = eof_q;
  assign tx_sof_pos_o  = '0;
  assign tx_eof_pos_o  = eof_pos_q;
  assign tx_src_rdy_o  = src_rdy_q;
  assign frames_sent_o = frames_q;

endmodule

// File: tb/tb_mfb_frame_gen.sv
// Bench for mfb_frame_gen: a frame-level model checks every cycle, directed
// literal checks pin the framing, pattern, throughput and reset behaviour.
module tb_mfb_frame_gen;
  localparam int RS = 8, BS = 8, IW = 8, MW = 16, LW = 16;
  localparam int WI = RS * BS;
  localparam int DW = WI * IW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] req_len;
  logic [MW-1:0] req_meta;
  logic          req_vld;
  logic          req_rdy;
  logic [DW-1:0] tx_data;
  logic [MW-1:0] tx_meta;
  logic          tx_sof, tx_eof;
  logic [2:0]    tx_sof_pos;
  logic [5:0]    tx_eof_pos;
  logic          tx_src_rdy;
  logic          tx_dst_rdy;
  logic [31:0]   frames_sent;

  int checks = 0;
  int failures = 0;
  int q_len[$];
  logic [MW-1:0] q_meta[$];
  int widx = 0;
  logic [31:0] frames_m = 32'd0;
  bit up = 1'b0;
  int dst_mode = 0;

  always #5 clk = ~clk;

  mfb_frame_gen #(.REGION_SIZE(RS), .BLOCK_SIZE(BS), .ITEM_WIDTH(IW),
                  .META_WIDTH(MW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_len_i(req_len), .req_meta_i(req_meta), .req_vld_i(req_vld), .req_rdy_o(req_rdy),
    .tx_data_o(tx_data), .tx_meta_o(tx_meta), .tx_sof_o(tx_sof), .tx_eof_o(tx_eof),
    .tx_sof_pos_o(tx_sof_pos), .tx_eof_pos_o(tx_eof_pos), .tx_src_rdy_o(tx_src_rdy),
    .tx_dst_rdy_i(tx_dst_rdy), .frames_sent_o(frames_sent));

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink ready: mode 0 always ready, mode 1 repeating 1,0,0,1.
  initial begin
    int ph;
    int prev;
    ph = 0;
    prev = 0;
    tx_dst_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (dst_mode != prev) ph = 0;
      prev = dst_mode;
      if (dst_mode == 0) tx_dst_rdy = 1'b1;
      else tx_dst_rdy = ((ph % 4) == 0) || ((ph % 4) == 3);
      ph++;
    end
  end

  // Frame-level model: the head frame of the queue and its word index define the bus.
  initial begin
    int len, words;
    bit last;
    logic [DW-1:0] exp_data;
    forever begin
      @(posedge clk);
      if (rst_n) up = 1'b1;
      @(negedge clk);
      if (!rst_n) begin
        up = 1'b0;
        q_len.delete();
        q_meta.delete();
        widx = 0;
        frames_m = 32'd0;
        chk("rst_src_rdy", DW'(tx_src_rdy), DW'(1'b0));
        chk("rst_req_rdy", DW'(req_rdy), DW'(1'b0));
        chk("rst_frames", DW'(frames_sent), DW'(32'd0));
      end else if (q_len.size() == 0) begin
        chk("idle_src_rdy", DW'(tx_src_rdy), DW'(1'b0));
        chk("idle_req_rdy", DW'(req_rdy), DW'(up));
        chk("idle_frames", DW'(frames_sent), DW'(frames_m));
      end else begin
        len = q_len[0];
        words = (len + WI - 1) / WI;
        last = (widx == words - 1);
        exp_data = '0;
        for (int i = 0; i < WI; i++) begin
          if (widx * WI + i < len) exp_data[i*IW +: IW] = IW'((widx * WI + i) % 256);
        end
        chk("src_rdy", DW'(tx_src_rdy), DW'(1'b1));
        chk("data", tx_data, exp_data);
        chk("sof", DW'(tx_sof), DW'(widx == 0));
        chk("eof", DW'(tx_eof), DW'(last));
        chk("sof_pos", DW'(tx_sof_pos), DW'(3'd0));
        if (last) chk("eof_pos", DW'(tx_eof_pos), DW'((len - 1) % WI));
        if (widx == 0) chk("meta", DW'(tx_meta), DW'(q_meta[0]));
        chk("req_rdy", DW'(req_rdy), DW'(last && tx_dst_rdy));
        chk("frames", DW'(frames_sent), DW'(frames_m));
        if (tx_dst_rdy) begin
          if (last) begin
            void'(q_len.pop_front());
            void'(q_meta.pop_front());
            widx = 0;
            frames_m = frames_m + 32'd1;
          end else begin
            widx++;
          end
        end
      end
    end
  end

  // Offer one request; returns #1 after the accepting edge.
  task automatic req(input int len, input logic [MW-1:0] meta);
    bit ok;
    ok = 1'b0;
    req_len = LW'(len);
    req_meta = meta;
    req_vld = 1'b1;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = req_rdy;
      @(posedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: request len %0d not accepted, required acceptance", len);
    end else if (len != 0) begin
      q_len.push_back(len);
      q_meta.push_back(meta);
    end
    #1;
    req_vld = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q_len.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (q_len.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d frames pending, required 0", q_len.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    int t;
    rst_n = 1'b0;
    req_vld = 1'b0;
    req_len = '0;
    req_meta = '0;
    #1;
    chk("reset_src_rdy", DW'(tx_src_rdy), DW'(1'b0));
    chk("reset_data", tx_data, '0);
    chk("reset_req_rdy", DW'(req_rdy), DW'(1'b0));
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("up_req_rdy", DW'(req_rdy), DW'(1'b1));

    req(1, 16'hA5A5);
    chk("single_sof", DW'(tx_sof), DW'(1'b1));
    chk("single_eof", DW'(tx_eof), DW'(1'b1));
    chk("single_eof_pos", DW'(tx_eof_pos), DW'(6'd0));
    chk("single_item0", DW'(tx_data[7:0]), DW'(8'h00));
    chk("single_meta", DW'(tx_meta), DW'(16'hA5A5));
    drain();
    chk("single_frames", DW'(frames_sent), DW'(32'd1));

    req(64, 16'h1234);
    chk("w64_eof", DW'(tx_eof), DW'(1'b1));
    chk("w64_eof_pos", DW'(tx_eof_pos), DW'(6'd63));
    chk("w64_item63", DW'(tx_data[63*8 +: 8]), DW'(8'h3F));
    drain();
    req(65, 16'h0042);
    chk("w65_w0_sof", DW'(tx_sof), DW'(1'b1));
    chk("w65_w0_eof", DW'(tx_eof), DW'(1'b0));
    @(posedge clk);
    #1;
    chk("w65_w1_eof", DW'(tx_eof), DW'(1'b1));
    chk("w65_w1_eof_pos", DW'(tx_eof_pos), DW'(6'd0));
    chk("w65_w1_item0", DW'(tx_data[7:0]), DW'(8'h40));
    chk("w65_w1_item1", DW'(tx_data[15:8]), DW'(8'h00));
    drain();
    chk("w65_frames", DW'(frames_sent), DW'(32'd3));

    @(negedge clk);
    dst_mode = 1;
    @(posedge clk);
    #1;
    req(200, 16'hBEEF);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(tx_src_rdy && tx_eof) && t < 100);
    chk("bp_eof_seen", DW'(tx_src_rdy && tx_eof), DW'(1'b1));
    chk("bp_w3_item0", DW'(tx_data[7:0]), DW'(8'hC0));
    chk("bp_eof_pos", DW'(tx_eof_pos), DW'(6'd7));
    drain();
    chk("bp_frames", DW'(frames_sent), DW'(32'd4));
    @(negedge clk);
    dst_mode = 0;
    @(posedge clk);
    #1;

    req(130, 16'h0130);
    t0 = $time;
    req(1, 16'h0001);
    req(64, 16'h0064);
    chk("b2b_gap", DW'($time - t0), DW'(40));
    drain();
    chk("b2b_frames", DW'(frames_sent), DW'(32'd7));

    req(0, 16'h0000);
    chk("zero_no_word", DW'(tx_src_rdy), DW'(1'b0));
    req(2, 16'h0002);
    drain();
    chk("zero_frames", DW'(frames_sent), DW'(32'd8));

    req(300, 16'h0300);
    @(posedge clk);
    #2;
    chk("mid_word1_sof", DW'(tx_sof), DW'(1'b0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_src_rdy", DW'(tx_src_rdy), DW'(1'b0));
    chk("mid_rst_eof", DW'(tx_eof), DW'(1'b0));
    chk("mid_rst_data", tx_data, '0);
    chk("mid_rst_meta", DW'(tx_meta), DW'(16'h0000));
    chk("mid_rst_eof_pos", DW'(tx_eof_pos), DW'(6'd0));
    chk("mid_rst_frames", DW'(frames_sent), DW'(32'd0));
    chk("mid_rst_req_rdy", DW'(req_rdy), DW'(1'b0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    req(5, 16'h0005);
    chk("post_sof", DW'(tx_sof), DW'(1'b1));
    chk("post_eof", DW'(tx_eof), DW'(1'b1));
    chk("post_eof_pos", DW'(tx_eof_pos), DW'(6'd4));
    chk("post_item4", DW'(tx_data[39:32]), DW'(8'h04));
    chk("post_item5", DW'(tx_data[47:40]), DW'(8'h00));
    drain();
    chk("post_frames", DW'(frames_sent), DW'(32'd1));

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
